audio_queue: RTL and testbench



---
 rtl/eq_pkg.sv | 22 ++
 rtl/queue_dpram.sv | 41 ++++
 rtl/audio_queue.sv | 167 ++++++++++++++++
 tb/tb_audio_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the equalizer datapath.
//   QUEUE_DEPTH   : samples held per band window (also sizes the FIR coefficient ROM)
//   SMPL_W        : signed sample width per channel
//   queue_state_t : audio_queue control states
// -----------------------------------------------------------------------------
package eq_pkg;

  localparam int QUEUE_DEPTH = 1021;
  localparam int SMPL_W      = 16;

  // FILL : fewer than QUEUE_DEPTH samples stored since reset
  // IDLE : window full, waiting for the next sample
  // SEQ  : playing the window out oldest-to-newest
  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2
  } queue_state_t;

endpackage : eq_pkg

// File: rtl/queue_dpram.sv
// -----------------------------------------------------------------------------
// queue_dpram
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old
// contents (read-before-write).
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   re       in   read enable; rd_data updates on the next edge
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module queue_dpram
  import eq_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = 2 * SMPL_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only control
  // state is reset. Non-blocking assignments give read-before-write here:
  // the read samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule : queue_dpram

// File: rtl/audio_queue.sv
// -----------------------------------------------------------------------------
// audio_queue
// Stereo circular sample queue feeding one FIR band filter. Holds the most
// recent DEPTH left/right pairs; on each new sample (once full) it plays the
// whole window oldest-to-newest, one pair per clock, with sequencing high.
// A sample arriving during a burst is stored and schedules exactly one
// follow-on burst, separated from the current one by one low cycle.
//
// Optional build macro AUDIO_QUEUE_OVF_EN adds the sticky ovf output: set
// when a sample arrives during a burst that already has a follow-on pending.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   wrt_smpl    in   one-cycle strobe, new pair on lft_smpl/rht_smpl
//   lft_smpl    in   signed left sample
//   rht_smpl    in   signed right sample
//   lft_out     out  left sample being played (registered, holds after burst)
//   rht_out     out  right sample being played (registered, holds after burst)
//   sequencing  out  high for DEPTH consecutive cycles per burst
//   ovf         out  (AUDIO_QUEUE_OVF_EN only) sticky coalescing overflow
// -----------------------------------------------------------------------------
module audio_queue
  import eq_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = SMPL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt_smpl,
  input  logic [WIDTH-1:0] lft_smpl,
  input  logic [WIDTH-1:0] rht_smpl,
  output logic [WIDTH-1:0] lft_out,
  output logic [WIDTH-1:0] rht_out,
  output logic             sequencing
`ifdef AUDIO_QUEUE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  queue_state_t    state, state_nxt;
  logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [CW-1:0]   rd_cnt, rd_cnt_nxt;    // reads issued in the current burst
  logic            pend, pend_nxt;
  logic            start;
  logic            gap;
  logic            rd_en;
  logic            rd_vld;
  logic [2*WIDTH-1:0] rd_data;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // rd_cnt == DEPTH inside SEQ marks the single idle cycle between a burst
  // and its pending follow-on; no read is issued then.
  assign gap   = (state == SEQ) && (rd_cnt == FULL_CNT);
  assign rd_en = (state == SEQ) && !gap;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_nxt = wrt_smpl ? ptr_inc(wr_ptr) : wr_ptr;
    count_nxt  = (wrt_smpl && count != FULL_CNT) ? count + CW'(1) : count;
    rd_ptr_nxt = rd_en ? ptr_inc(rd_ptr) : rd_ptr;
    rd_cnt_nxt = rd_en ? rd_cnt + CW'(1) : rd_cnt;
    pend_nxt   = pend | (wrt_smpl && state == SEQ);
    state_nxt  = state;
    start      = 1'b0;

    unique case (state)
      FILL: if (wrt_smpl && count == LAST_CNT) start = 1'b1;
      IDLE: if (wrt_smpl) start = 1'b1;
      SEQ: begin
        if (gap) begin
          start = 1'b1;
        end else if (rd_cnt == LAST_CNT && !(pend || wrt_smpl)) begin
          state_nxt = IDLE;
        end
        // With a follow-on pending, rd_cnt steps to DEPTH and the next
        // cycle is the gap.
      end
      default: state_nxt = FILL;
    endcase

    // A burst always starts at the post-write pointer, i.e. the oldest
    // entry including any sample written on this same edge.
    if (start) begin
      state_nxt  = SEQ;
      rd_ptr_nxt = wr_ptr_nxt;
      rd_cnt_nxt = '0;
      pend_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_cnt <= '0;
      pend   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      rd_cnt <= rd_cnt_nxt;
      pend   <= pend_nxt;
    end
  end

  queue_dpram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (wrt_smpl),
    .wr_addr (wr_ptr),
    .wr_data ({lft_smpl, rht_smpl}),
    .re      (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Read address at edge k, RAM data after k, output register after k+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld     <= 1'b0;
      sequencing <= 1'b0;
      lft_out    <= '0;
      rht_out    <= '0;
    end else begin
      rd_vld     <= rd_en;
      sequencing <= rd_vld;
      if (rd_vld) begin
        lft_out <= rd_data[2*WIDTH-1:WIDTH];
        rht_out <= rd_data[WIDTH-1:0];
      end
    end
  end

`ifdef AUDIO_QUEUE_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (wrt_smpl && state == SEQ && pend) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule : audio_queue

// File: tb/tb_audio_queue.sv
// -----------------------------------------------------------------------------
// tb_audio_queue
// Self-checking bench for audio_queue (default build or AUDIO_QUEUE_OVF_EN).
// A monitor keeps the history of every written pair and, whenever a burst
// starts, expects the burst to be the last DEPTH pairs written up to two
// edges before sequencing rose.
// -----------------------------------------------------------------------------
module tb_audio_queue;

  localparam int DEPTH = 1021;
  localparam int W     = 16;

  logic         clk;
  logic         rst_n;
  logic         wrt_smpl;
  logic [W-1:0] lft_smpl;
  logic [W-1:0] rht_smpl;
  logic [W-1:0] lft_out;
  logic [W-1:0] rht_out;
  logic         sequencing;
`ifdef AUDIO_QUEUE_OVF_EN
  logic         ovf;
`endif

  audio_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rht_smpl   (rht_smpl),
    .lft_out    (lft_out),
    .rht_out    (rht_out),
    .sequencing (sequencing)
`ifdef AUDIO_QUEUE_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] neg16(input int v);
    return W'(-v);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model / monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    int           e;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } hist_t;

  hist_t        hist[$];
  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_r[$];
  int           edge_cnt  = 0;
  bit           in_burst  = 0;
  bit           seq_seen  = 0;
  int           blen      = 0;
  int           bad_smpl  = 0;
  int           n_bursts  = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      hist.delete();
      in_burst = 0;
    end else if (wrt_smpl) begin
      hist.push_back('{edge_cnt, lft_smpl, rht_smpl});
      if (hist.size() > 3 * DEPTH) void'(hist.pop_front());
    end
    #1;
    if (rst_n) begin
      if (sequencing) begin
        seq_seen = 1;
        if (!in_burst) begin
          in_burst = 1;
          blen     = 0;
          bad_smpl = 0;
          exp_l.delete();
          exp_r.delete();
          for (int i = hist.size() - 1; i >= 0 && exp_l.size() < DEPTH; i--) begin
            if (hist[i].e <= edge_cnt - 2) begin
              exp_l.push_front(hist[i].l);
              exp_r.push_front(hist[i].r);
            end
          end
          check("burst_window_full", exp_l.size(), DEPTH);
        end
        if (blen < exp_l.size()) begin
          if (lft_out !== exp_l[blen] || rht_out !== exp_r[blen]) begin
            if (bad_smpl == 0)
              $display("  burst sample %0d: got %h/%h want %h/%h",
                       blen, lft_out, rht_out, exp_l[blen], exp_r[blen]);
            bad_smpl++;
          end
        end
        blen++;
      end else if (in_burst) begin
        in_burst = 0;
        n_bursts++;
        check("burst_len", blen, DEPTH);
        check("burst_bad_samples", bad_smpl, 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end on a falling edge)
  // ---------------------------------------------------------------------------
  int cur_off;

  task automatic tick();
    @(negedge clk);
    cur_off++;
  endtask

  task automatic write_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    wrt_smpl = 1'b1;
    lft_smpl = l;
    rht_smpl = r;
    tick();
    wrt_smpl = 1'b0;
  endtask

  task automatic advance_to(input int off);
    while (cur_off < off) tick();
  endtask

  task automatic expect_out(input string name, input logic s, input int l);
    check({name, "_seq"}, sequencing, s);
    check({name, "_lft"}, lft_out, W'(l));
    check({name, "_rht"}, rht_out, neg16(l));
  endtask

  typedef struct {
    int   offset;   // falling edges after the triggering write's edge
    logic exp_seq;
    int   exp_val;  // expected lft_out; rht_out expected as its negation
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n_rand_bursts;

    vecs[0] = '{0,    1'b0, 0};
    vecs[1] = '{1,    1'b0, 0};
    vecs[2] = '{2,    1'b1, 1};
    vecs[3] = '{3,    1'b1, 2};
    vecs[4] = '{500,  1'b1, 499};
    vecs[5] = '{1022, 1'b1, 1021};
    vecs[6] = '{1023, 1'b0, 1021};
    vecs[7] = '{1025, 1'b0, 1021};

    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    lft_smpl = '0;
    rht_smpl = '0;
    cur_off  = 0;
    repeat (3) @(negedge clk);
    expect_out("reset", 1'b0, 0);
`ifdef AUDIO_QUEUE_OVF_EN
    check("reset_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1020 pairs: window not yet full
    seq_seen = 0;
    for (int i = 1; i <= DEPTH - 1; i++) write_pair(W'(i), neg16(i));
    repeat (5) tick();
    check("no_burst_before_full", seq_seen, 0);

    // 1021st pair triggers the first burst; table of exact timing points
    cur_off = -1;
    write_pair(W'(DEPTH), neg16(DEPTH));
    for (int v = 0; v < 8; v++) begin
      advance_to(vecs[v].offset);
      expect_out($sformatf("first_burst_off%0d", vecs[v].offset), vecs[v].exp_seq, vecs[v].exp_val);
    end

    // 1022nd pair: window slides by one, read pointer wraps
    cur_off = -1;
    write_pair(W'(1022), neg16(1022));
    advance_to(1);    expect_out("wrap_pre", 1'b0, 1021);
    advance_to(2);    expect_out("wrap_first", 1'b1, 2);
    advance_to(1021); expect_out("wrap_slot_last", 1'b1, 1021);
    advance_to(1022); expect_out("wrap_newest", 1'b1, 1022);
    advance_to(1023); expect_out("wrap_end", 1'b0, 1022);

    // Two strobes during one burst coalesce into a single follow-on burst
    cur_off = -1;
    write_pair(W'(1023), neg16(1023));
    advance_to(100);
    write_pair(W'(1024), neg16(1024));
    advance_to(300);
    write_pair(W'(1025), neg16(1025));
    advance_to(1022); expect_out("pend_b1_last", 1'b1, 1023);
    advance_to(1023); expect_out("pend_gap", 1'b0, 1023);
    advance_to(1024); expect_out("pend_b2_first", 1'b1, 5);
    advance_to(2044); expect_out("pend_b2_last", 1'b1, 1025);
    advance_to(2045); expect_out("pend_b2_end", 1'b0, 1025);
    advance_to(2060); check("pend_no_third", sequencing, 0);
`ifdef AUDIO_QUEUE_OVF_EN
    check("pend_ovf", ovf, 1);
`endif

    // Reset in the middle of a burst
    cur_off = -1;
    write_pair(W'(1026), neg16(1026));
    advance_to(501);  expect_out("rst_pre", 1'b1, 505);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 0);
`ifdef AUDIO_QUEUE_OVF_EN
    check("rst_ovf_clear", ovf, 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    seq_seen = 0;
    for (int i = 1; i <= DEPTH - 1; i++) write_pair(W'(2000 + i), neg16(2000 + i));
    repeat (5) tick();
    check("rst_no_burst_before_full", seq_seen, 0);
    cur_off = -1;
    write_pair(W'(2000 + DEPTH), neg16(2000 + DEPTH));
    advance_to(2);    expect_out("rst_refill_first", 1'b1, 2001);
    advance_to(1022); expect_out("rst_refill_last", 1'b1, 2000 + DEPTH);
    advance_to(1023); expect_out("rst_refill_end", 1'b0, 2000 + DEPTH);

    // Same-slot hazard: second write lands on the slot read on that edge
    cur_off = -1;
    write_pair(W'(4000), neg16(4000));
    write_pair(W'(4001), neg16(4001));
    advance_to(2);    expect_out("hazard_old_value", 1'b1, 2002);
    advance_to(1022); expect_out("hazard_b1_last", 1'b1, 4000);
    advance_to(1023); expect_out("hazard_gap", 1'b0, 4000);
    advance_to(1024); expect_out("hazard_b2_first", 1'b1, 2003);
    advance_to(2044); expect_out("hazard_new_value", 1'b1, 4001);
    advance_to(2045); check("hazard_end_seq", sequencing, 0);

    // Random sparse writes, checked by the monitor's window model
    n_rand_bursts = n_bursts;
    write_pair(W'($urandom), W'($urandom));
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 249) == 0) write_pair(W'($urandom), W'($urandom));
      else tick();
    end
    repeat (2 * DEPTH + 50) tick();
    check("rand_bursts_seen", (n_bursts > n_rand_bursts), 1);
    check("rand_drained", sequencing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_audio_queue
